// File: rtl/vga_timing_generator.sv
// VGA raster timing: free-running pixel/line counters, combinational position
// flags, and a one-clock output register stage that keeps colour and syncs aligned.
module vga_timing_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        vgaCLK,
  input  logic        reset,
  input  logic [11:0] colorIn,
  output logic [9:0]  pixelX,
  output logic [9:0]  pixelY,
  output logic        pixelValid,
  output logic        frameTick,
  output logic        vBlank,
  output logic [3:0]  redVGA,
  output logic [3:0]  greenVGA,
  output logic [3:0]  blueVGA,
  output logic        horizontalVGA,
  output logic        verticalVGA
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [9:0]  h_count_q, h_count_d;
  logic [9:0]  v_count_q, v_count_d;
  logic [11:0] rgb_q, rgb_d;
  logic        h_sync_q, h_sync_d;
  logic        v_sync_q, v_sync_d;
  logic        h_last, v_last;
  logic        active;

  always_comb begin
    h_last    = (h_count_q == H_LAST);
    v_last    = (v_count_q == V_LAST);
    active    = (h_count_q < H_ACT) && (v_count_q < V_ACT);
    h_count_d = h_last ? 10'd0 : h_count_q + 10'd1;
    v_count_d = v_count_q;
    if (h_last) begin
      v_count_d = v_last ? 10'd0 : v_count_q + 10'd1;
    end
    // Blanking colour outside the active area also keeps RGB dark during syncs.
    rgb_d    = active ? colorIn : 12'd0;
    h_sync_d = !((h_count_q >= H_SYNC_BEG) && (h_count_q < H_SYNC_END));
    v_sync_d = !((v_count_q >= V_SYNC_BEG) && (v_count_q < V_SYNC_END));
  end

  always_ff @(posedge vgaCLK) begin
    if (reset) begin
      h_count_q <= 10'd0;
      v_count_q <= 10'd0;
      rgb_q     <= 12'd0;
      h_sync_q  <= 1'b1;
      v_sync_q  <= 1'b1;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      rgb_q     <= rgb_d;
      h_sync_q  <= h_sync_d;
      v_sync_q  <= v_sync_d;
    end
  end

  assign pixelX        = h_count_q;
  assign pixelY        = v_count_q;
  assign pixelValid    = active;
  assign frameTick     = (h_count_q == 10'd0) && (v_count_q == 10'd0);
  assign vBlank        = (v_count_q >= V_ACT);
  assign redVGA        = rgb_q[11:8];
  assign greenVGA      = rgb_q[7:4];
  assign blueVGA       = rgb_q[3:0];
  assign horizontalVGA = h_sync_q;
  assign verticalVGA   = v_sync_q;

endmodule
